// File: rtl/alarm_reporter.sv
// Serial status transmitter: sends {header, byte1, byte2, checksum} UART frames on status change.
// Optional heartbeat packet when idle is enabled by defining ALARM_REPORTER_HEARTBEAT_EN.
module alarm_reporter #(
  parameter int CLKS_PER_BIT     = 16,
  parameter int HEARTBEAT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alarms,
  input  logic       lights_on,
  input  logic       heat_on,
  input  logic       cool_on,
  input  logic       sprink_on,
  input  logic       pump_on,
  input  logic [7:0] occupants_in,
  output logic       tx,
  output logic       busy,
  output logic [7:0] pkt_count
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255 ||
      HEARTBEAT_CYCLES < 16 || HEARTBEAT_CYCLES > 65535) begin : g_bad_params
    $error("alarm_reporter: parameter out of legal range");
  end

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HEADER    = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GUARD
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [1:0]  frame_cnt_reg, frame_cnt_next;
  logic [15:0] last_sent_reg, last_sent_next;
  logic [7:0]  pkt_count_reg, pkt_count_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;

  logic [15:0] status_word;
  logic        baud_done;
  logic        start_ok;
  logic        start_pkt;
  logic        hb_fire;
  logic [7:0]  cur_byte;

  assign status_word = {alarms, lights_on, heat_on, cool_on, sprink_on, pump_on, occupants_in};
  assign baud_done   = (baud_cnt_reg == BAUD_LAST);

  // A change pending at the end of the guard time launches straight into the next
  // packet, so back-to-back packets are spaced by exactly the busy period.
  assign start_ok  = (state_reg == IDLE) || (state_reg == GUARD && baud_done);
  assign start_pkt = start_ok && ((status_word != last_sent_reg) || hb_fire);

`ifdef ALARM_REPORTER_HEARTBEAT_EN
  localparam logic [15:0] HB_LAST = 16'(HEARTBEAT_CYCLES - 1);

  logic [15:0] hb_cnt_reg, hb_cnt_next;

  assign hb_fire = (state_reg == IDLE) && (hb_cnt_reg == HB_LAST);

  always_comb begin
    hb_cnt_next = hb_cnt_reg;
    if (start_pkt) begin
      hb_cnt_next = 16'd0;
    end else if (state_reg == IDLE) begin
      hb_cnt_next = hb_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_cnt_reg <= 16'd0;
    end else begin
      hb_cnt_reg <= hb_cnt_next;
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= 8'd0;
      bit_cnt_reg   <= 3'd0;
      frame_cnt_reg <= 2'd0;
      last_sent_reg <= 16'h0000;
      pkt_count_reg <= 8'd0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      last_sent_reg <= last_sent_next;
      pkt_count_reg <= pkt_count_next;
      tx_reg        <= tx_next;
      busy_reg      <= busy_next;
    end
  end

  // Baud counter restarts at every bit boundary, so bit timing never accumulates drift.
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_done ? 8'd0 : baud_cnt_reg + 8'd1;
    bit_cnt_next   = bit_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    last_sent_next = last_sent_reg;
    pkt_count_next = pkt_count_reg;
    if (start_pkt) begin
      state_next     = START;
      baud_cnt_next  = 8'd0;
      bit_cnt_next   = 3'd0;
      frame_cnt_next = 2'd0;
      last_sent_next = status_word;
      pkt_count_next = pkt_count_reg + 8'd1;
    end else begin
      case (state_reg)
        IDLE: begin
          baud_cnt_next = 8'd0;
        end
        START: begin
          if (baud_done) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_cnt_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_done) begin
            if (frame_cnt_reg == 2'd3) begin
              state_next = GUARD;
            end else begin
              state_next     = START;
              frame_cnt_next = frame_cnt_reg + 2'd1;
            end
          end
        end
        GUARD: begin
          if (baud_done) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Frame payloads come only from the snapshot, never from the live inputs.
  always_comb begin
    cur_byte  = HEADER;
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    case (frame_cnt_next)
      2'd0: cur_byte = HEADER;
      2'd1: cur_byte = last_sent_reg[15:8];
      2'd2: cur_byte = last_sent_reg[7:0];
      2'd3: cur_byte = last_sent_reg[15:8] ^ last_sent_reg[7:0];
      default: cur_byte = HEADER;
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_cnt_next];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx        = tx_reg;
  assign busy      = busy_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_alarm_reporter.sv
// Directed bench for alarm_reporter: decodes serial packets and checks bytes, timing and counters.
// Heartbeat checks are included when ALARM_REPORTER_HEARTBEAT_EN is defined.
module tb_alarm_reporter;

  localparam int CPB        = 4;
  localparam int HB         = 64;
  localparam int PKT_CYCLES = 41 * CPB;
`ifdef ALARM_REPORTER_HEARTBEAT_EN
  localparam int HOLD_CYCLES = 10;
`else
  localparam int HOLD_CYCLES = 200;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] alarms = 3'b000;
  logic       lights_on = 1'b0;
  logic       heat_on = 1'b0;
  logic       cool_on = 1'b0;
  logic       sprink_on = 1'b0;
  logic       pump_on = 1'b0;
  logic [7:0] occupants_in = 8'd0;
  logic       tx;
  logic       busy;
  logic [7:0] pkt_count;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_run = 0;
  int last_busy_len = 0;

  typedef struct {
    logic [2:0]  alarms;
    logic [4:0]  act;
    logic [7:0]  occ;
    logic [31:0] exp_pkt;
  } vec_t;

  vec_t vecs [5];

  alarm_reporter #(
    .CLKS_PER_BIT    (CPB),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alarms      (alarms),
    .lights_on   (lights_on),
    .heat_on     (heat_on),
    .cool_on     (cool_on),
    .sprink_on   (sprink_on),
    .pump_on     (pump_on),
    .occupants_in(occupants_in),
    .tx          (tx),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else begin
      busy_run <= 0;
      if (busy_run != 0) last_busy_len <= busy_run;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [4:0] act, input logic [7:0] occ);
    alarms       = a;
    lights_on    = act[4];
    heat_on      = act[3];
    cool_on      = act[2];
    sprink_on    = act[1];
    pump_on      = act[0];
    occupants_in = occ;
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: busy=%b after %0d cycles, expected %b", name, busy, n, lvl);
    end
  endtask

  // Samples each bit two cycles into its period; bytes packed {f0,f1,f2,f3}.
  task automatic capture(input string name, output logic [31:0] pkt, output int start_cyc);
    int waited;
    int pos;
    bit found;
    logic [9:0] fr;
    pkt = '0;
    start_cyc = -1;
    found = 1'b0;
    waited = 0;
    fr = '0;
    while (!found && waited < 2000) begin
      @(negedge clk);
      waited++;
      if (tx === 1'b0) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no start bit within %0d cycles, expected one", name, waited);
    end else begin
      start_cyc = cyc;
      pos = 0;
      for (int f = 0; f < 4; f++) begin
        for (int j = 0; j < 10; j++) begin
          while (pos < (f * 10 + j) * CPB + 2) begin
            @(negedge clk);
            pos++;
          end
          fr[j] = tx;
        end
        check($sformatf("%s_frame%0d_start_stop", name, f), {30'd0, fr[9], fr[0]}, 32'd2);
        pkt[31 - 8 * f -: 8] = fr[8:1];
      end
      $display("packet %s: start cycle %0d bytes %h", name, start_cyc, pkt);
    end
  endtask

  initial begin
    logic [31:0] p1, p2;
    int s1, s2, c;
    bit tx_low, busy_high, cnt_nz;

    vecs[0] = '{3'b100, 5'b10000, 8'h03, 32'hA5900393};
    vecs[1] = '{3'b011, 5'b01001, 8'hFF, 32'hA569FF96};
    vecs[2] = '{3'b000, 5'b00110, 8'h5A, 32'hA5065A5C};
    vecs[3] = '{3'b111, 5'b11111, 8'h80, 32'hA5FF807F};
    vecs[4] = '{3'b000, 5'b00000, 8'h00, 32'hA5000000};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pkt_count", {24'd0, pkt_count}, 32'd0);
    reset = 1'b0;

    tx_low = 1'b0;
    busy_high = 1'b0;
    cnt_nz = 1'b0;
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low = 1'b1;
      if (busy !== 1'b0) busy_high = 1'b1;
      if (pkt_count !== 8'd0) cnt_nz = 1'b1;
    end
    check("idle_tx_low_seen", {31'd0, tx_low}, 32'd0);
    check("idle_busy_seen", {31'd0, busy_high}, 32'd0);
    check("idle_pkt_count_nonzero", {31'd0, cnt_nz}, 32'd0);

    // First packet, with occupancy changed mid-flight.
    drive(3'b100, 5'b10000, 8'd3);
    c = cyc;
    fork
      capture("pkt_a", p1, s1);
      begin
        repeat (20) @(negedge clk);
        occupants_in = 8'd4;
      end
    join
    check("pkt_a_bytes", p1, 32'hA5900393);
    check("pkt_a_latency", s1, c + 1);
    check("pkt_a_count", {24'd0, pkt_count}, 32'd1);
    capture("pkt_b", p2, s2);
    check("pkt_b_bytes", p2, 32'hA5900494);
    check("pkt_b_spacing", s2 - s1, PKT_CYCLES);
    check("pkt_b_count", {24'd0, pkt_count}, 32'd2);
    wait_busy(1'b0, 400, "pkt_b_end");

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].alarms, vecs[i].act, vecs[i].occ);
      c = cyc;
      capture($sformatf("vec%0d", i), p1, s1);
      check($sformatf("vec%0d_bytes", i), p1, vecs[i].exp_pkt);
      check($sformatf("vec%0d_latency", i), s1, c + 1);
      check($sformatf("vec%0d_count", i), {24'd0, pkt_count}, 32'(3 + i));
      wait_busy(1'b0, 400, $sformatf("vec%0d_end", i));
      @(negedge clk);
      check($sformatf("vec%0d_busy_len", i), last_busy_len, PKT_CYCLES);
    end

    // Reset in the middle of a packet abandons it.
    drive(3'b100, 5'b10000, 8'd5);
    @(negedge clk);
    check("rst_mid_start_bit", {31'd0, tx}, 32'd0);
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_count", {24'd0, pkt_count}, 32'd0);
    reset = 1'b0;
    c = cyc;
    capture("pkt_after_reset", p1, s1);
    check("pkt_after_reset_bytes", p1, 32'hA5900595);
    check("pkt_after_reset_latency", s1, c + 1);
    check("pkt_after_reset_count", {24'd0, pkt_count}, 32'd1);
    wait_busy(1'b0, 400, "pkt_after_reset_end");

`ifdef ALARM_REPORTER_HEARTBEAT_EN
    capture("hb1", p1, s1);
    check("hb1_bytes", p1, 32'hA5900595);
    check("hb1_count", {24'd0, pkt_count}, 32'd2);
    capture("hb2", p2, s2);
    check("hb2_bytes", p2, 32'hA5900595);
    check("hb_spacing", s2 - s1, HB + PKT_CYCLES);
    check("hb2_count", {24'd0, pkt_count}, 32'd3);
    wait_busy(1'b0, 400, "hb2_end");
`endif

    // Counter wrap over 256 packets.
    drive(3'b000, 5'b00000, 8'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("wrap_start_count", {24'd0, pkt_count}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      occupants_in = 8'(i + 1);
      wait_busy(1'b1, 4, $sformatf("wrap%0d_start", i));
      check($sformatf("wrap%0d_count", i), {24'd0, pkt_count}, {24'd0, 8'(i + 1)});
      wait_busy(1'b0, 400, $sformatf("wrap%0d_end", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
